// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with grant hold: a winner keeps its grant until release or
// abort, and may take up to its weight in back-to-back grants before priority rotates past it.
module wrr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int WEIGHT_W = 4,
    parameter int ID_W     = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NUM_REQ-1:0]          i_req,
    input  logic [NUM_REQ*WEIGHT_W-1:0] i_weight,
    input  logic                        i_rel,
    output logic [NUM_REQ-1:0]          o_grant,
    output logic                        o_grant_vld,
    output logic [ID_W-1:0]             o_grant_id
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    state_t              r_state;
    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    r_cur;
    logic [WEIGHT_W-1:0] r_credit;
    logic [NUM_REQ-1:0]  r_grant;
    logic                r_grant_vld;
    logic [ID_W-1:0]     r_grant_id;

    logic [WEIGHT_W-1:0] w_weight [NUM_REQ];
    logic [IDX_W-1:0]    w_next_ptr;
    logic [IDX_W-1:0]    w_search_ptr;
    pick_t               w_pick;
    logic [NUM_REQ-1:0]  w_pick_onehot;
    logic [WEIGHT_W-1:0] w_win_weight;
    logic [WEIGHT_W-1:0] w_load_credit;
    logic                w_cur_req;
    logic                w_burst;
    logic                w_release;
    logic                w_load;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_weight
        assign w_weight[g] = i_weight[g*WEIGHT_W +: WEIGHT_W];
    end

    // First set request at or after start, wrapping; the descending scan leaves the nearest one.
    function automatic pick_t find_winner(input logic [NUM_REQ-1:0] req,
                                          input logic [IDX_W-1:0]   start);
        pick_t res;
        int    pos;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = int'(start) + k;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            if (req[IDX_W'(pos)]) begin
                res.found = 1'b1;
                res.idx   = IDX_W'(pos);
            end
        end
        return res;
    endfunction

    assign w_next_ptr    = (r_cur == IDX_W'(NUM_REQ - 1)) ? '0 : r_cur + IDX_W'(1);
    assign w_search_ptr  = (r_state == ST_IDLE) ? r_ptr : w_next_ptr;
    assign w_pick        = find_winner(i_req, w_search_ptr);
    assign w_pick_onehot = NUM_REQ'(1) << w_pick.idx;
    assign w_win_weight  = w_weight[w_pick.idx];
    // A zero weight behaves like one: a single grant, no extra credit.
    assign w_load_credit = (w_win_weight == '0) ? '0 : w_win_weight - WEIGHT_W'(1);

    assign w_cur_req = i_req[r_cur];
    assign w_burst   = (r_state == ST_GRANT) && i_rel && w_cur_req && (r_credit != '0);
    assign w_release = (r_state == ST_GRANT) && !w_burst && (i_rel || !w_cur_req);
    assign w_load    = w_pick.found && ((r_state == ST_IDLE) || w_release);

    // NOTE: every register here, state and outputs alike, uses the async reset so a
    // mid-grant reset drops the grant immediately without waiting for a clock edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_cur       <= '0;
            r_credit    <= '0;
            r_grant     <= '0;
            r_grant_vld <= 1'b0;
            r_grant_id  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every decision uses pre-edge state.
            if (w_release) r_ptr <= w_next_ptr;

            if (w_burst) begin
                r_credit <= r_credit - WEIGHT_W'(1);
            end else if (w_load) begin
                r_state     <= ST_GRANT;
                r_cur       <= w_pick.idx;
                r_credit    <= w_load_credit;
                r_grant     <= w_pick_onehot;
                r_grant_vld <= 1'b1;
                r_grant_id  <= ID_W'(w_pick.idx);
            end else if (w_release) begin
                r_state     <= ST_IDLE;
                r_credit    <= '0;
                r_grant     <= '0;
                r_grant_vld <= 1'b0;
                r_grant_id  <= '0;
            end
        end
    end

    assign o_grant     = r_grant;
    assign o_grant_vld = r_grant_vld;
    assign o_grant_id  = r_grant_id;

endmodule
